// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, access-size constant
// and the memory-side control bundle.
package data_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DBG_ISSUE = 2'd1,
    DBG_DONE  = 2'd2
  } arb_state_e;

  localparam logic [2:0] FUNCT3_WORD = 3'b010;

  typedef struct packed {
    logic       read;
    logic       write;
    logic [2:0] funct3;
  } mem_ctrl_t;

endpackage

// File: rtl/data_mem_arbiter_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates one data memory between the CPU MEM stage and a debug/loader
// port; the CPU has priority until the debug port has starved STARVE_LIMIT cycles.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int MEM_ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH        = 32,
  parameter int STARVE_LIMIT      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         CpuReq,
  input  logic                         CpuWe,
  input  logic [MEM_ADDRESS_WIDTH-1:0] CpuAddr,
  input  logic [DATA_WIDTH-1:0]        CpuWData,
  input  logic [2:0]                   CpuFunct3,
  output logic                         CpuStall,
  output logic [DATA_WIDTH-1:0]        CpuRData,
  input  logic                         DbgReq,
  input  logic                         DbgWe,
  input  logic [MEM_ADDRESS_WIDTH-1:0] DbgAddr,
  input  logic [DATA_WIDTH-1:0]        DbgWData,
  output logic                         DbgAck,
  output logic [DATA_WIDTH-1:0]        DbgRData,
  output logic                         MemRead,
  output logic                         MemWrite,
  output logic [MEM_ADDRESS_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0]        MemWData,
  output logic [2:0]                   MemFunct3,
  input  logic [DATA_WIDTH-1:0]        MemRData,
  output logic [15:0]                  StallCount
);

  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  arb_state_e                   state_q, state_d;
  logic [2:0]                   starve_q, starve_d;
  logic                         dbg_we_q;
  logic [MEM_ADDRESS_WIDTH-1:0] dbg_addr_q;
  logic [DATA_WIDTH-1:0]        dbg_wdata_q;
  logic                         latch_en;
  mem_ctrl_t                    ctrl;

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    latch_en  = 1'b0;
    ctrl      = '0;
    MemAddr   = CpuAddr;
    MemWData  = CpuWData;
    CpuStall  = 1'b0;
    DbgAck    = 1'b0;
    DbgRData  = '0;
    case (state_q)
      IDLE: begin
        ctrl.read   = CpuReq & ~CpuWe;
        ctrl.write  = CpuReq & CpuWe;
        ctrl.funct3 = CpuFunct3;
        if (DbgReq && (!CpuReq || starve_q == STARVE_MAX)) begin
          state_d  = DBG_ISSUE;
          starve_d = '0;
          latch_en = 1'b1;
        end else if (!DbgReq) begin
          starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
          starve_d = starve_q + 3'd1;
        end
      end
      DBG_ISSUE: begin
        ctrl.read   = ~dbg_we_q;
        ctrl.write  = dbg_we_q;
        ctrl.funct3 = FUNCT3_WORD;
        MemAddr     = dbg_addr_q;
        MemWData    = dbg_wdata_q;
        CpuStall    = CpuReq;
        state_d     = DBG_DONE;
      end
      DBG_DONE: begin
        // Read data issued in DBG_ISSUE arrives from memory this cycle.
        ctrl.funct3 = FUNCT3_WORD;
        MemAddr     = dbg_addr_q;
        MemWData    = dbg_wdata_q;
        DbgAck      = 1'b1;
        DbgRData    = dbg_we_q ? '0 : MemRData;
        CpuStall    = CpuReq;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      dbg_we_q    <= 1'b0;
      dbg_addr_q  <= '0;
      dbg_wdata_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      if (latch_en) begin
        dbg_we_q    <= DbgWe;
        dbg_addr_q  <= DbgAddr;
        dbg_wdata_q <= DbgWData;
      end
    end
  end

  assign MemRead   = ctrl.read;
  assign MemWrite  = ctrl.write;
  assign MemFunct3 = ctrl.funct3;
  assign CpuRData  = MemRData;

  sat_counter #(
    .WIDTH(16)
  ) u_stall_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (CpuStall),
    .count_o(StallCount)
  );

endmodule
